// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: post-header byte stream in, one RGBA pixel
// out per accepted beat.
// Ports: clk, rst_n (async active-low), start/num_pixels (frame setup),
//   in_data/in_valid/in_ready (byte stream), out_pixel/out_valid/out_ready
//   (pixel stream), busy (frame in progress), done (end-of-frame pulse).

package qoi_types;
  typedef logic [31:0] pixel_t;
  typedef logic [7:0]  byte_t;
  typedef logic [29:0] size_t;
  typedef logic [5:0]  index_t;

  localparam byte_t QOI_OP_INDEX = 8'h00;
  localparam byte_t QOI_OP_DIFF  = 8'h40;
  localparam byte_t QOI_OP_LUMA  = 8'h80;
  localparam byte_t QOI_OP_RUN   = 8'hC0;
  localparam byte_t QOI_OP_RGB   = 8'hFE;
  localparam byte_t QOI_OP_RGBA  = 8'hFF;
  localparam byte_t QOI_MASK_2   = 8'hC0;
endpackage

module qoi_decoder #(
  parameter int INDEX_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [29:0] num_pixels,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  import qoi_types::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_ARG,
    S_EMIT,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam pixel_t PREV_INIT = 32'hFF00_0000;

  state_t state_q, state_d;
  size_t  rem_q, rem_d;
  logic [5:0] run_q, run_d;
  logic [2:0] need_q, need_d;
  logic [1:0] pos_q, pos_d;
  logic   luma_q, luma_d;
  byte_t  dg_q, dg_d;
  pixel_t px_q, px_d;
  pixel_t prev_q, prev_d;
  logic   done_q, done_d;

  // Per-entry valid bits give a one-cycle clear of the colour index.
  logic [INDEX_DEPTH-1:0] vld_q, vld_d;
  pixel_t idx_mem [INDEX_DEPTH];

  logic   idx_we;
  index_t idx_wa;
  pixel_t idx_wd;
  pixel_t idx_rd;

  logic in_fire;
  logic out_fire;

  byte_t pr, pg, pb, pa;
  byte_t tag;
  logic  op_rgb, op_rgba;
  logic  op_index, op_diff;
  logic  op_luma, op_run;

  function automatic index_t qoi_hash(
    input pixel_t p
  );
    logic [12:0] s;
    s = 13'(p[7:0])   * 13'd3
      + 13'(p[15:8])  * 13'd5
      + 13'(p[23:16]) * 13'd7
      + 13'(p[31:24]) * 13'd11;
    return s[5:0];
  endfunction

  assign pr = prev_q[7:0];
  assign pg = prev_q[15:8];
  assign pb = prev_q[23:16];
  assign pa = prev_q[31:24];

  assign in_ready  = (state_q == S_OP) ||
                     (state_q == S_ARG);
  assign out_valid = (state_q == S_EMIT) ||
                     (state_q == S_RUN);
  assign out_pixel = (state_q == S_EMIT) ? px_q :
                     (state_q == S_RUN)  ? prev_q :
                     '0;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // 8-bit opcodes take precedence over the 2-bit tags they alias.
  assign tag      = in_data & QOI_MASK_2;
  assign op_rgb   = (in_data == QOI_OP_RGB);
  assign op_rgba  = (in_data == QOI_OP_RGBA);
  assign op_index = (tag == QOI_OP_INDEX);
  assign op_diff  = (tag == QOI_OP_DIFF);
  assign op_luma  = (tag == QOI_OP_LUMA);
  assign op_run   = (tag == QOI_OP_RUN) &&
                    !op_rgb && !op_rgba;

  // The table is a register, so an entry written on an EMIT accept is
  // already visible to an INDEX chunk in the following OP cycle.
  assign idx_rd = vld_q[in_data[5:0]] ?
                  idx_mem[in_data[5:0]] : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    run_d   = run_q;
    need_d  = need_q;
    pos_d   = pos_q;
    luma_d  = luma_q;
    dg_d    = dg_q;
    px_d    = px_q;
    prev_d  = prev_q;
    done_d  = 1'b0;
    vld_d   = vld_q;
    idx_we  = 1'b0;
    idx_wa  = qoi_hash(px_q);
    idx_wd  = px_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_pixels != '0) begin
            rem_d   = num_pixels;
            prev_d  = PREV_INIT;
            vld_d   = '0;
            state_d = S_OP;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_OP: begin
        if (in_fire) begin
          unique case (1'b1)
            op_rgb: begin
              px_d    = prev_q;
              need_d  = 3'd3;
              pos_d   = 2'd0;
              luma_d  = 1'b0;
              state_d = S_ARG;
            end
            op_rgba: begin
              px_d    = prev_q;
              need_d  = 3'd4;
              pos_d   = 2'd0;
              luma_d  = 1'b0;
              state_d = S_ARG;
            end
            op_index: begin
              px_d    = idx_rd;
              state_d = S_EMIT;
            end
            op_diff: begin
              px_d = {
                pa,
                pb + {6'd0, in_data[1:0]} - 8'd2,
                pg + {6'd0, in_data[3:2]} - 8'd2,
                pr + {6'd0, in_data[5:4]} - 8'd2
              };
              state_d = S_EMIT;
            end
            op_luma: begin
              dg_d    = {2'd0, in_data[5:0]} - 8'd32;
              need_d  = 3'd1;
              luma_d  = 1'b1;
              state_d = S_ARG;
            end
            op_run: begin
              run_d   = in_data[5:0] + 6'd1;
              state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end

      S_ARG: begin
        if (in_fire) begin
          if (luma_q) begin
            px_d = {
              pa,
              pb + dg_q + {4'd0, in_data[3:0]} - 8'd8,
              pg + dg_q,
              pr + dg_q + {4'd0, in_data[7:4]} - 8'd8
            };
          end else begin
            unique case (pos_q)
              2'd0: px_d[7:0]   = in_data;
              2'd1: px_d[15:8]  = in_data;
              2'd2: px_d[23:16] = in_data;
              2'd3: px_d[31:24] = in_data;
            endcase
          end
          pos_d  = pos_q + 2'd1;
          need_d = need_q - 3'd1;
          if (need_q == 3'd1) begin
            state_d = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (out_fire) begin
          prev_d = px_q;
          idx_we = 1'b1;
          rem_d  = rem_q - size_t'(1);
          if (rem_q == size_t'(1)) begin
            done_d  = 1'b1;
            state_d = S_FLUSH;
          end else begin
            state_d = S_OP;
          end
        end
      end

      S_RUN: begin
        if (out_fire) begin
          // Rewriting prev into the table is harmless and keeps it in
          // step with a software decoder.
          idx_we = 1'b1;
          idx_wa = qoi_hash(prev_q);
          idx_wd = prev_q;
          rem_d  = rem_q - size_t'(1);
          run_d  = run_q - 6'd1;
          if (rem_q == size_t'(1)) begin
            done_d  = 1'b1;
            state_d = S_FLUSH;
          end else if (run_q == 6'd1) begin
            state_d = S_OP;
          end
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (idx_we) begin
      vld_d[idx_wa] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      run_q   <= '0;
      need_q  <= '0;
      pos_q   <= '0;
      luma_q  <= 1'b0;
      dg_q    <= '0;
      px_q    <= '0;
      prev_q  <= PREV_INIT;
      done_q  <= 1'b0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      run_q   <= run_d;
      need_q  <= need_d;
      pos_q   <= pos_d;
      luma_q  <= luma_d;
      dg_q    <= dg_d;
      px_q    <= px_d;
      prev_q  <= prev_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
    end
  end

  // Data storage needs no reset; the valid bits mask stale entries.
  always_ff @(posedge clk) begin
    if (idx_we) begin
      idx_mem[idx_wa] <= idx_wd;
    end
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: table of frames with hand-computed
// pixels, plus stall, zero-length and mid-frame reset sequences.
module tb_qoi_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [29:0] num_pixels;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qoi_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pixels (num_pixels),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_pixel  (out_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string              name;
    int                 n;
    int                 nb;
    logic [0:7][7:0]    b;
    int                 ne;
    logic [0:5][31:0]   e;
    int                 stall;
  } vec_t;

  localparam logic [31:0] Z = 32'h0;

  vec_t vecs[12];
  int   nv = 0;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(
    input string nm,
    input int n,
    input int nb,
    input logic [63:0] b,
    input int ne,
    input logic [191:0] e,
    input int stall
  );
    vecs[nv].name  = nm;
    vecs[nv].n     = n;
    vecs[nv].nb    = nb;
    vecs[nv].b     = b;
    vecs[nv].ne    = ne;
    vecs[nv].e     = e;
    vecs[nv].stall = stall;
    nv++;
  endtask

  // Streams one frame with in_valid held high; once the chunk bytes are
  // used up a trailing 00 is offered and must never be taken.
  task automatic run_frame(input vec_t v);
    int k = 0;
    int bi = 0;
    int extra = 0;
    int st = 0;
    bit fin = 0;
    @(negedge clk);
    start = 1'b1;
    num_pixels = 30'(v.n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ":busy_hi"}, busy, 1);
    for (int c = 0; c < 300 && !fin; c++) begin
      if (done) begin
        fin = 1;
        in_valid = 1'b0;
        chk({v.name, ":busy_at_done"}, busy, 1);
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          if (k < v.ne && k == v.stall && st < 3) begin
            out_ready = 1'b0;
            chk({v.name, ":stall_px"}, out_pixel, v.e[k]);
            chk({v.name, ":stall_rdy"}, in_ready, 0);
            st++;
          end else if (k < v.ne) begin
            chk($sformatf("%s:px%0d", v.name, k), out_pixel, v.e[k]);
            k++;
          end else begin
            k++;
          end
        end
        in_valid = 1'b1;
        in_data = (bi < v.nb) ? v.b[bi] : 8'h00;
        if (in_ready) begin
          if (bi < v.nb) bi++;
          else extra++;
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk({v.name, ":done_seen"}, 32'(fin), 1);
    chk({v.name, ":npix"}, k, v.ne);
    chk({v.name, ":nbytes"}, bi, v.nb);
    chk({v.name, ":extra_bytes"}, extra, 0);
    @(negedge clk);
    chk({v.name, ":busy_lo"}, busy, 0);
    chk({v.name, ":done_lo"}, done, 0);
  endtask

  vec_t tail;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    num_pixels = '0;
    in_data = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst:in_ready", in_ready, 0);
    chk("rst:out_valid", out_valid, 0);
    chk("rst:out_pixel", out_pixel, 0);
    chk("rst:busy", busy, 0);
    chk("rst:done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    add("rgb_run", 2, 5, 64'hFE102030_C0000000,
        2, {32'hFF302010, 32'hFF302010, Z, Z, Z, Z}, -1);
    add("idx_unwritten", 3, 7, 64'hFF010203_04400000,
        3, {32'h04030201, 32'h040100FF, 32'h0, Z, Z, Z}, -1);
    add("idx_hash14", 3, 7, 64'hFF010203_04400E00,
        3, {32'h04030201, 32'h040100FF, 32'h04030201, Z, Z, Z}, -1);
    add("idx_hash48", 3, 7, 64'hFF010203_04403000,
        3, {32'h04030201, 32'h040100FF, 32'h040100FF, Z, Z, Z}, -1);
    add("idx_cleared", 1, 1, 64'h0E000000_00000000,
        1, {32'h0, Z, Z, Z, Z, Z}, -1);
    add("luma_neg", 1, 2, 64'h80880000_00000000,
        1, {32'hFFE0E0E0, Z, Z, Z, Z, Z}, -1);
    add("luma_pos", 1, 2, 64'hBFFF0000_00000000,
        1, {32'hFF261F26, Z, Z, Z, Z, Z}, -1);
    add("diff_pos", 2, 2, 64'h7F660000_00000000,
        2, {32'hFF010101, 32'hFF010001, Z, Z, Z, Z}, -1);
    add("run_stall", 5, 6, 64'hC3FF1122_33440000,
        5, {32'hFF000000, 32'hFF000000, 32'hFF000000,
            32'hFF000000, 32'h44332211, Z}, 2);
    add("run_trunc", 2, 1, 64'hFD000000_00000000,
        2, {32'hFF000000, 32'hFF000000, Z, Z, Z, Z}, -1);

    for (int i = 0; i < nv; i++) begin
      run_frame(vecs[i]);
    end

    // Zero-pixel frame: done pulses, decoder stays idle.
    @(negedge clk);
    start = 1'b1;
    num_pixels = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero:done", done, 1);
    chk("zero:busy", busy, 0);
    chk("zero:in_ready", in_ready, 0);
    @(negedge clk);
    chk("zero:done_lo", done, 0);

    // Reset in the middle of an RGBA argument sequence.
    @(negedge clk);
    start = 1'b1;
    num_pixels = 30'd1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid:in_arg", in_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid:in_ready", in_ready, 0);
    chk("mid:out_valid", out_valid, 0);
    chk("mid:out_pixel", out_pixel, 0);
    chk("mid:busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid:no_done", done, 0);
    end
    rst_n = 1'b1;
    tail.name = "after_rst";
    tail.n = 1;
    tail.nb = 1;
    tail.b = 64'h40000000_00000000;
    tail.ne = 1;
    tail.e = {32'hFFFEFEFE, Z, Z, Z, Z, Z};
    tail.stall = -1;
    run_frame(tail);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
